alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DATA_W, default 16, width of one register-file word and each ALU result.
REQ-002 Parameter ADDR_W, default 5, width of destination register address (instruction fields [25:21], [20:16]).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  opcode, destinations and ALU results valid this cycle.
REQ-006 in_ready  output  1  block can accept a new result set this cycle.
REQ-007 opcode  input  6  instruction bits [31:26].
REQ-008 rdst1 / rdst2  input  ADDR_W each  low-word / high-word destination register.
REQ-009 sum, diff, negate, divi  input  DATA_W each  ADD, SUB, NEG, DIV results.
REQ-010 or_gat, xor_gat, nand_gat, nor_gat, xnor_gat, not_gat  input  DATA_W each  logic results.
REQ-011 multiplied  input  2*DATA_W  MUL result.
REQ-012 wr_en  output  1  register-file write strobe.
REQ-013 wr_addr  output  ADDR_W  register-file write address.
REQ-014 wr_data  output  DATA_W  register-file write data.
REQ-015 done  output  1  one-cycle pulse on last write of an instruction, or on acceptance cycle+1 of an unsupported opcode.
REQ-016 err  output  1  one-cycle pulse, unsupported opcode accepted.
REQ-017 zero_flag  output  1  registered: last written result was all zeros.

Function
REQ-018 Supported opcodes SHALL be: 000100 ADD, 000101 SUB, 000110 NEG, 000111 MUL, 001000 DIV, 001001 OR, 001010 XOR, 001011 NAND, 001100 NOR, 001101 XNOR, 001110 NOT.
REQ-019 FSM states SHALL be IDLE, WR_LO, WR_HI; in_ready=1 only in IDLE.
REQ-020 Handshake: accept when in_valid & in_ready; SHALL capture opcode, rdst1, rdst2 and selected result (32 bits for MUL, zero-extended 16 otherwise) into registers that hold until the next accept.
REQ-021 IDLE->WR_LO on accept of supported opcode; WR_LO->WR_HI if MUL else ->IDLE; WR_HI->IDLE.
REQ-022 WR_LO: wr_en=1, wr_addr=rdst1, wr_data=result[15:0]; WR_HI: wr_en=1, wr_addr=rdst2, wr_data=result[31:16].
REQ-023 Latency: accept at cycle N -> low write at N+1; MUL high write at N+2; next accept earliest N+2 (non-MUL) or N+3 (MUL).
REQ-024 Unsupported opcode (MOV, LOAD, STORE, shifts, >=010001) SHALL be accepted, stay in IDLE, assert err and done at N+1, no write, zero_flag unchanged.
REQ-025 wr_en, wr_addr, wr_data, done, err SHALL be registered outputs; wr_addr/wr_data SHALL be 0 whenever wr_en=0.
REQ-026 zero_flag SHALL update at the low write: 1 iff full captured result (32 bits for MUL) is zero.
REQ-027 MUL with rdst1==rdst2 SHALL perform both writes in order; high word is final content.
REQ-028 in_valid while in_ready=0 SHALL be ignored; inputs need not be held.

Reset
REQ-029 rst SHALL force IDLE, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, zero_flag=0.
REQ-030 rst during WR_LO or WR_HI SHALL suppress any write in the following cycle; instruction is discarded without done.
REQ-031 rst has priority over a simultaneous accept.

Structure
REQ-032 Opcode constants, FSM state encoding and DATA_W/ADDR_W defaults SHALL live in a shared ALU package used also by the decoder and ALU mux.
REQ-033 One sub-module alu_result_sel (combinational opcode-to-result mux with supported flag) SHALL be instantiated; FSM and registers stay in alu_writeback.

Verification
REQ-034 ADD, sum=16'h1234, rdst1=3 -> one cycle later wr_en=1, wr_addr=3, wr_data=16'h1234, done=1, zero_flag=0.
REQ-035 MUL, multiplied=32'hABCD_0012, rdst1=4, rdst2=5 -> N+1 write (4,16'h0012), N+2 write (5,16'hABCD), done only at N+2, in_ready=0 at N+1,N+2.
REQ-036 MUL, multiplied=32'h0001_0000 -> zero_flag=0; then XOR result 16'h0000 -> zero_flag=1.
REQ-037 opcode 000010 (LOAD) -> err=1 and done=1 at N+1, wr_en stays 0, zero_flag unchanged.
REQ-038 MUL accepted, rst asserted at N+1 -> no wr_en at N+2, all outputs at reset values, next ADD accepted normally.
REQ-039 Back-to-back in_valid with ADD then SUB -> SUB accepted only at N+2, writes at N+3 with diff value.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback slice: default widths, opcode
// encodings and the writeback FSM state type.
package alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;
    localparam int OPCODE_W   = 6;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 6'b000110;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'b001001;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_NAND = 6'b001011;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_XNOR = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 6'b001110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    function automatic logic is_mul_op(input logic [OPCODE_W-1:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_result_sel.sv
// Combinational opcode-to-result mux; results are zero-extended to the
// double-width MUL format and flagged when the opcode writes back.
module alu_result_sel
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DATA_W-1:0]   sum,
    input  logic [DATA_W-1:0]   diff,
    input  logic [DATA_W-1:0]   negate,
    input  logic [DATA_W-1:0]   divi,
    input  logic [DATA_W-1:0]   or_gat,
    input  logic [DATA_W-1:0]   xor_gat,
    input  logic [DATA_W-1:0]   nand_gat,
    input  logic [DATA_W-1:0]   nor_gat,
    input  logic [DATA_W-1:0]   xnor_gat,
    input  logic [DATA_W-1:0]   not_gat,
    input  logic [2*DATA_W-1:0] multiplied,
    output logic [2*DATA_W-1:0] result,
    output logic                supported
);

    logic [DATA_W-1:0] narrow;

    always_comb begin
        narrow    = '0;
        supported = 1'b1;
        unique case (opcode)
            OP_ADD:  narrow = sum;
            OP_SUB:  narrow = diff;
            OP_NEG:  narrow = negate;
            OP_MUL:  narrow = '0;
            OP_DIV:  narrow = divi;
            OP_OR:   narrow = or_gat;
            OP_XOR:  narrow = xor_gat;
            OP_NAND: narrow = nand_gat;
            OP_NOR:  narrow = nor_gat;
            OP_XNOR: narrow = xnor_gat;
            OP_NOT:  narrow = not_gat;
            default: supported = 1'b0;
        endcase
    end

    assign result = is_mul_op(opcode) ? multiplied : {{DATA_W{1'b0}}, narrow};

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: accepts one ALU result set, writes it to the register file
// (two words for MUL) and reports completion, errors and a zero flag.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [ADDR_W-1:0]   rdst1,
    input  logic [ADDR_W-1:0]   rdst2,
    input  logic [DATA_W-1:0]   sum,
    input  logic [DATA_W-1:0]   diff,
    input  logic [DATA_W-1:0]   negate,
    input  logic [DATA_W-1:0]   divi,
    input  logic [DATA_W-1:0]   or_gat,
    input  logic [DATA_W-1:0]   xor_gat,
    input  logic [DATA_W-1:0]   nand_gat,
    input  logic [DATA_W-1:0]   nor_gat,
    input  logic [DATA_W-1:0]   xnor_gat,
    input  logic [DATA_W-1:0]   not_gat,
    input  logic [2*DATA_W-1:0] multiplied,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                done,
    output logic                err,
    output logic                zero_flag
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [ADDR_W-1:0]   rdst2_q, rdst2_d;
    logic [DATA_W-1:0]   result_hi_q, result_hi_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                zero_q, zero_d;

    logic [2*DATA_W-1:0] sel_result;
    logic                sel_supported;
    logic                accept;

    alu_result_sel #(
        .DATA_W(DATA_W)
    ) u_result_sel (
        .opcode    (opcode),
        .sum       (sum),
        .diff      (diff),
        .negate    (negate),
        .divi      (divi),
        .or_gat    (or_gat),
        .xor_gat   (xor_gat),
        .nand_gat  (nand_gat),
        .nor_gat   (nor_gat),
        .xnor_gat  (xnor_gat),
        .not_gat   (not_gat),
        .multiplied(multiplied),
        .result    (sel_result),
        .supported (sel_supported)
    );

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // The low word and rdst1 go straight into the write registers on accept;
    // only what the high-word cycle needs is held in capture registers.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        rdst2_d     = rdst2_q;
        result_hi_d = result_hi_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        zero_d      = zero_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    opcode_d    = opcode;
                    rdst2_d     = rdst2;
                    result_hi_d = sel_result[2*DATA_W-1:DATA_W];
                    if (sel_supported) begin
                        state_d   = WR_LO;
                        wr_en_d   = 1'b1;
                        wr_addr_d = rdst1;
                        wr_data_d = sel_result[DATA_W-1:0];
                        done_d    = !is_mul_op(opcode);
                        zero_d    = (sel_result == '0);
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            WR_LO: begin
                if (is_mul_op(opcode_q)) begin
                    state_d   = WR_HI;
                    wr_en_d   = 1'b1;
                    wr_addr_d = rdst2_q;
                    wr_data_d = result_hi_q;
                    done_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_HI:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            rdst2_q     <= '0;
            result_hi_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            rdst2_q     <= rdst2_d;
            result_hi_q <= result_hi_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            zero_q      <= zero_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign zero_flag = zero_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed and randomized bench for alu_writeback, checked against an
// instruction-level reference model of the writeback behaviour.
module tb_alu_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [4:0]  rdst1, rdst2;
    logic [15:0] sum, diff, negate, divi;
    logic [15:0] or_gat, xor_gat, nand_gat, nor_gat, xnor_gat, not_gat;
    logic [31:0] multiplied;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        done, err, zero_flag;

    int n_cmp = 0;
    int n_err = 0;
    logic model_zero;

    alu_writeback #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rdst1(rdst1), .rdst2(rdst2),
        .sum(sum), .diff(diff), .negate(negate), .divi(divi),
        .or_gat(or_gat), .xor_gat(xor_gat), .nand_gat(nand_gat),
        .nor_gat(nor_gat), .xnor_gat(xnor_gat), .not_gat(not_gat),
        .multiplied(multiplied),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .err(err), .zero_flag(zero_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_inputs();
        rdst1 = 5'($urandom);     rdst2 = 5'($urandom);
        sum = 16'($urandom);      diff = 16'($urandom);
        negate = 16'($urandom);   divi = 16'($urandom);
        or_gat = 16'($urandom);   xor_gat = 16'($urandom);
        nand_gat = 16'($urandom); nor_gat = 16'($urandom);
        xnor_gat = 16'($urandom); not_gat = 16'($urandom);
        multiplied = $urandom;
    endtask

    task automatic zero_results();
        sum = '0; diff = '0; negate = '0; divi = '0; or_gat = '0; xor_gat = '0;
        nand_gat = '0; nor_gat = '0; xnor_gat = '0; not_gat = '0; multiplied = '0;
    endtask

    // Reference: result an opcode writes back; codes 4..14 are the ALU ops.
    function automatic logic ref_op(input logic [5:0] op, output logic [31:0] res);
        res = 32'h0;
        if (op < 6'd4 || op > 6'd14) return 1'b0;
        case (op)
            6'd4:  res = {16'h0, sum};
            6'd5:  res = {16'h0, diff};
            6'd6:  res = {16'h0, negate};
            6'd7:  res = multiplied;
            6'd8:  res = {16'h0, divi};
            6'd9:  res = {16'h0, or_gat};
            6'd10: res = {16'h0, xor_gat};
            6'd11: res = {16'h0, nand_gat};
            6'd12: res = {16'h0, nor_gat};
            6'd13: res = {16'h0, xnor_gat};
            default: res = {16'h0, not_gat};
        endcase
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".wr_en"}, wr_en, 0);
        check({tag, ".wr_addr"}, wr_addr, 0);
        check({tag, ".wr_data"}, wr_data, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".err"}, err, 0);
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".zero"}, zero_flag, model_zero);
    endtask

    // Issue one instruction with the current operand values and follow it to completion.
    task automatic run_instr(input string tag, input logic [5:0] op);
        logic [31:0] res;
        logic        sup, mul;
        logic [4:0]  a1, a2;
        opcode = op;
        sup = ref_op(op, res);
        mul = (op == 6'd7);
        a1 = rdst1; a2 = rdst2;
        check({tag, ".ready_pre"}, in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        randomize_inputs();
        opcode = 6'($urandom);
        if (!sup) begin
            check({tag, ".err"}, err, 1);
            check({tag, ".done"}, done, 1);
            check({tag, ".wr_en"}, wr_en, 0);
            check({tag, ".wr_addr"}, wr_addr, 0);
            check({tag, ".wr_data"}, wr_data, 0);
            check({tag, ".zero"}, zero_flag, model_zero);
            check({tag, ".ready"}, in_ready, 1);
        end else begin
            model_zero = (res == 32'h0);
            check({tag, ".lo_en"}, wr_en, 1);
            check({tag, ".lo_addr"}, wr_addr, a1);
            check({tag, ".lo_data"}, wr_data, res[15:0]);
            check({tag, ".lo_done"}, done, !mul);
            check({tag, ".lo_err"}, err, 0);
            check({tag, ".lo_zero"}, zero_flag, model_zero);
            check({tag, ".lo_ready"}, in_ready, 0);
            if (mul) begin
                @(posedge clk); #1;
                check({tag, ".hi_en"}, wr_en, 1);
                check({tag, ".hi_addr"}, wr_addr, a2);
                check({tag, ".hi_data"}, wr_data, res[31:16]);
                check({tag, ".hi_done"}, done, 1);
                check({tag, ".hi_ready"}, in_ready, 0);
                check({tag, ".hi_zero"}, zero_flag, model_zero);
            end
        end
        @(posedge clk); #1;
        check_idle({tag, ".after"});
    endtask

    initial begin
        logic [5:0] op;
        rst = 1'b1; in_valid = 1'b0; opcode = '0;
        randomize_inputs();
        model_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        // ADD single write
        randomize_inputs(); sum = 16'h1234; rdst1 = 5'd3;
        run_instr("add", 6'b000100);

        // MUL two-word write
        randomize_inputs(); multiplied = 32'hABCD_0012; rdst1 = 5'd4; rdst2 = 5'd5;
        run_instr("mul", 6'b000111);

        // zero flag uses the full MUL width, then a zero XOR
        randomize_inputs(); multiplied = 32'h0001_0000;
        run_instr("mul_z", 6'b000111);
        check("mul_z.flag", zero_flag, 0);
        randomize_inputs(); xor_gat = 16'h0000;
        run_instr("xor_z", 6'b001010);
        check("xor_z.flag", zero_flag, 1);

        // LOAD is unsupported: zero flag must stay set
        randomize_inputs();
        run_instr("load", 6'b000010);
        check("load.flag", zero_flag, 1);

        // MUL to the same register twice
        randomize_inputs(); rdst2 = rdst1;
        run_instr("mul_same", 6'b000111);

        // reset during WR_LO of a MUL
        randomize_inputs(); opcode = 6'b000111; multiplied = 32'h1111_2222;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_mul.lo_en", wr_en, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_zero = 1'b0;
        check_idle("rst_mul");
        randomize_inputs();
        run_instr("rst_mul.add", 6'b000100);

        // reset wins over a simultaneous accept
        randomize_inputs(); opcode = 6'b000100; sum = 16'h0;
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        model_zero = 1'b0;
        check_idle("rst_acc");

        // back-to-back valid: SUB waits until IDLE
        randomize_inputs(); opcode = 6'b000100; sum = 16'h0042; rdst1 = 5'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        model_zero = 1'b0;
        randomize_inputs(); opcode = 6'b000101; rdst1 = 5'd9; diff = 16'hBEEF;
        check("b2b.add_en", wr_en, 1);
        check("b2b.add_addr", wr_addr, 7);
        check("b2b.add_data", wr_data, 16'h0042);
        check("b2b.add_ready", in_ready, 0);
        @(posedge clk); #1;
        check("b2b.gap_en", wr_en, 0);
        check("b2b.gap_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b.sub_en", wr_en, 1);
        check("b2b.sub_addr", wr_addr, 9);
        check("b2b.sub_data", wr_data, 16'hBEEF);
        check("b2b.sub_done", done, 1);
        @(posedge clk); #1;
        check_idle("b2b.after");

        // randomized instruction mix
        for (int i = 0; i < 120; i++) begin
            randomize_inputs();
            if ($urandom_range(0, 3) == 0) zero_results();
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = 6'($urandom_range(4, 14));
            run_instr("rand", op);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
